// File: rtl/ccc_pll_sequencer.sv
`default_nettype none
// ============================================================================
// ccc_pll_sequencer : CCC/PLL power-up, reset, lock-qualify and retry
// sequencer with FlashFreeze handshake and clock-ready gating.
// Revision 1.0
// ============================================================================
module ccc_pll_sequencer #(
    parameter int PD_CYCLES           = 4,
    parameter int ARST_CYCLES         = 8,
    parameter int LOCK_FILTER_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int DRAIN_CYCLES        = 4
) (
    input  logic                             RCOSC_25_50MHZ,
    input  logic                             RESET_N,
    input  logic                             LOCK,
    input  logic                             FF_REQ,
    output logic                             PLL_POWERDOWN_N,
    output logic                             PLL_ARST_N,
    output logic                             CLK_READY,
    output logic                             FABRIC_RESET_N,
    output logic                             FF_ACK,
    output logic                             FAULT,
    output logic [$clog2(MAX_RETRIES+1)-1:0] RETRY_CNT
);

    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int MAX_A   = (PD_CYCLES > ARST_CYCLES) ? PD_CYCLES : ARST_CYCLES;
    localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > DRAIN_CYCLES) ? LOCK_TIMEOUT_CYCLES : DRAIN_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(LOCK_FILTER_CYCLES + 1);

    localparam logic [CW-1:0] PD_LAST    = CW'(PD_CYCLES);
    localparam logic [CW-1:0] ARST_LAST  = CW'(ARST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [FW-1:0] FILT_SAT   = FW'(LOCK_FILTER_CYCLES);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
    localparam logic [RW-1:0] RETRY_FULL = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PD        = 3'd0,
        S_ARST      = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_RUN       = 3'd3,
        S_DRAIN     = 3'd4,
        S_FROZEN    = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [FW-1:0]   filt;
    logic [FW-1:0]   filt_nxt;
    logic [RW-1:0]   retry_nxt;
    logic            lock_meta;
    logic            lock_s;
    logic            pd_n_nxt;
    logic            arst_n_nxt;
    logic            run_nxt;

    always_ff @(posedge RCOSC_25_50MHZ) begin
        if (!RESET_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
        filt_nxt  = '0;
        retry_nxt = RETRY_CNT;
        case (state)
            // One count longer than the others: from reset the hold is
            // measured from the first edge with RESET_N released.
            S_PD: begin
                if (cnt == PD_LAST) begin
                    state_nxt = S_ARST;
                    cnt_nxt   = '0;
                end
            end
            S_ARST: begin
                if (cnt == ARST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    filt_nxt = (filt == FILT_SAT) ? filt : filt + FW'(1);
                end
                if (lock_s && (filt == FILT_LAST)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    filt_nxt  = '0;
                    retry_nxt = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt  = '0;
                    filt_nxt = '0;
                    if (RETRY_CNT == RETRY_LAST) begin
                        state_nxt = S_FAULT;
                        retry_nxt = RETRY_FULL;
                    end else begin
                        state_nxt = S_PD;
                        retry_nxt = RETRY_CNT + RW'(1);
                    end
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_ARST;
                    cnt_nxt   = '0;
                end else if (FF_REQ) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_FROZEN;
                    cnt_nxt   = '0;
                end
            end
            S_FROZEN: begin
                if (!FF_REQ) begin
                    state_nxt = S_PD;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_PD;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the transition edge.
    always_comb begin
        pd_n_nxt   = (state_nxt == S_ARST) || (state_nxt == S_WAIT_LOCK) ||
                     (state_nxt == S_RUN)  || (state_nxt == S_DRAIN);
        arst_n_nxt = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_RUN) ||
                     (state_nxt == S_DRAIN);
        run_nxt    = (state_nxt == S_RUN);
    end

    always_ff @(posedge RCOSC_25_50MHZ) begin
        if (!RESET_N) begin
            state           <= S_PD;
            cnt             <= '0;
            filt            <= '0;
            RETRY_CNT       <= '0;
            PLL_POWERDOWN_N <= 1'b0;
            PLL_ARST_N      <= 1'b0;
            CLK_READY       <= 1'b0;
            FABRIC_RESET_N  <= 1'b0;
            FF_ACK          <= 1'b0;
            FAULT           <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            filt            <= filt_nxt;
            RETRY_CNT       <= retry_nxt;
            PLL_POWERDOWN_N <= pd_n_nxt;
            PLL_ARST_N      <= arst_n_nxt;
            CLK_READY       <= run_nxt;
            FABRIC_RESET_N  <= run_nxt;
            FF_ACK          <= (state_nxt == S_FROZEN);
            FAULT           <= (state_nxt == S_FAULT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccc_pll_sequencer.sv
`default_nettype none
// tb_ccc_pll_sequencer : table vectors, directed corner sequences and random
// stimulus against a deadline-based reference model checked every cycle.
module tb_ccc_pll_sequencer;

    localparam int PD_CYCLES   = 4;
    localparam int ARST_CYCLES = 8;
    localparam int FILT_CYCLES = 16;
    localparam int TO_CYCLES   = 64;
    localparam int MAX_RETRIES = 3;
    localparam int DRAIN_CYC   = 4;

    localparam int M_PD     = 0;
    localparam int M_ARST   = 1;
    localparam int M_WAIT   = 2;
    localparam int M_RUN    = 3;
    localparam int M_DRAIN  = 4;
    localparam int M_FROZEN = 5;
    localparam int M_FAULT  = 6;

    logic       clk;
    logic       RESET_N;
    logic       LOCK;
    logic       FF_REQ;
    logic       PLL_POWERDOWN_N;
    logic       PLL_ARST_N;
    logic       CLK_READY;
    logic       FABRIC_RESET_N;
    logic       FF_ACK;
    logic       FAULT;
    logic [1:0] RETRY_CNT;
    logic [7:0] dut_vec;

    ccc_pll_sequencer #(
        .PD_CYCLES          (PD_CYCLES),
        .ARST_CYCLES        (ARST_CYCLES),
        .LOCK_FILTER_CYCLES (FILT_CYCLES),
        .LOCK_TIMEOUT_CYCLES(TO_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES),
        .DRAIN_CYCLES       (DRAIN_CYC)
    ) dut (
        .RCOSC_25_50MHZ (clk),
        .RESET_N        (RESET_N),
        .LOCK           (LOCK),
        .FF_REQ         (FF_REQ),
        .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
        .PLL_ARST_N     (PLL_ARST_N),
        .CLK_READY      (CLK_READY),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .FF_ACK         (FF_ACK),
        .FAULT          (FAULT),
        .RETRY_CNT      (RETRY_CNT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign dut_vec = {PLL_POWERDOWN_N, PLL_ARST_N, CLK_READY, FABRIC_RESET_N,
                      FF_ACK, FAULT, RETRY_CNT};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase plus absolute entry edge; durations are checked
    // as edge differences, lock qualification as distance from the last low.
    int         ph        = M_PD;
    int         entry     = -1;
    int         qual_from = -1;
    int         nfail     = 0;
    int         edge_no   = -1;
    logic       p1        = 1'b0;
    logic       p2        = 1'b0;
    logic [7:0] mexp      = 8'h00;

    typedef struct {
        logic       r;
        logic       l;
        logic       f;
        int         n;
        logic [7:0] e;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, got, exp, edge_no);
        end
    endtask

    task automatic enter(input int p);
        ph        = p;
        entry     = edge_no;
        qual_from = edge_no;
    endtask

    task automatic model_edge(input logic r, input logic l, input logic f);
        logic ls;
        int   age;
        edge_no++;
        if (!r) begin
            edge_no = -1;
            enter(M_PD);
            nfail = 0;
            p1 = 1'b0;
            p2 = 1'b0;
        end else begin
            ls  = p2;
            p2  = p1;
            p1  = l;
            age = edge_no - entry;
            case (ph)
                M_PD:     if (age == PD_CYCLES + 1) enter(M_ARST);
                M_ARST:   if (age == ARST_CYCLES) enter(M_WAIT);
                M_WAIT: begin
                    if (!ls) qual_from = edge_no;
                    if (ls && (edge_no - qual_from == FILT_CYCLES)) begin
                        enter(M_RUN);
                        nfail = 0;
                    end else if (age == TO_CYCLES) begin
                        nfail++;
                        enter((nfail == MAX_RETRIES) ? M_FAULT : M_PD);
                    end
                end
                M_RUN: begin
                    if (!ls) enter(M_ARST);
                    else if (f) enter(M_DRAIN);
                end
                M_DRAIN:  if (age == DRAIN_CYC) enter(M_FROZEN);
                M_FROZEN: if (!f) begin enter(M_PD); nfail = 0; end
                default:  ;
            endcase
        end
        mexp = {(ph == M_ARST) || (ph == M_WAIT) || (ph == M_RUN) || (ph == M_DRAIN),
                (ph == M_WAIT) || (ph == M_RUN) || (ph == M_DRAIN),
                ph == M_RUN, ph == M_RUN, ph == M_FROZEN, ph == M_FAULT, nfail[1:0]};
    endtask

    task automatic step(input logic r, input logic l, input logic f);
        RESET_N = r;
        LOCK    = l;
        FF_REQ  = f;
        @(posedge clk);
        model_edge(r, l, f);
        #1;
        check("model", dut_vec, mexp);
    endtask

    task automatic run(input int n, input logic r, input logic l, input logic f);
        for (int i = 0; i < n; i++) step(r, l, f);
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic f,
                                input int n, input logic [7:0] e);
        vec_t v;
        v.r = r; v.l = l; v.f = f; v.n = n; v.e = e;
        return v;
    endfunction

    int   hit;
    int   lmode;
    logic rl;
    logic rf;

    initial begin
        RESET_N = 1'b0;
        LOCK    = 1'b0;
        FF_REQ  = 1'b0;

        // Bring-up, freeze, thaw, lock-loss; outputs {pd_n,arst_n,rdy,frst_n,ack,fault,retry}
        tbl[0]  = mk(0, 1, 0, 3,  8'b0000_0000);
        tbl[1]  = mk(1, 1, 0, 4,  8'b0000_0000);
        tbl[2]  = mk(1, 1, 0, 1,  8'b1000_0000);
        tbl[3]  = mk(1, 1, 0, 7,  8'b1000_0000);
        tbl[4]  = mk(1, 1, 0, 1,  8'b1100_0000);
        tbl[5]  = mk(1, 1, 0, 15, 8'b1100_0000);
        tbl[6]  = mk(1, 1, 0, 1,  8'b1111_0000);
        tbl[7]  = mk(1, 1, 0, 5,  8'b1111_0000);
        tbl[8]  = mk(1, 1, 1, 1,  8'b1100_0000);
        tbl[9]  = mk(1, 1, 1, 3,  8'b1100_0000);
        tbl[10] = mk(1, 1, 1, 1,  8'b0000_1000);
        tbl[11] = mk(1, 1, 1, 10, 8'b0000_1000);
        tbl[12] = mk(1, 1, 0, 1,  8'b0000_0000);
        tbl[13] = mk(1, 1, 0, 4,  8'b0000_0000);
        tbl[14] = mk(1, 1, 0, 1,  8'b1000_0000);
        tbl[15] = mk(1, 1, 0, 8,  8'b1100_0000);
        tbl[16] = mk(1, 1, 0, 16, 8'b1111_0000);
        tbl[17] = mk(1, 0, 0, 1,  8'b1111_0000);
        tbl[18] = mk(1, 1, 0, 1,  8'b1111_0000);
        tbl[19] = mk(1, 1, 0, 1,  8'b1000_0000);
        tbl[20] = mk(1, 1, 0, 7,  8'b1000_0000);
        tbl[21] = mk(1, 1, 0, 1,  8'b1100_0000);
        tbl[22] = mk(1, 1, 0, 15, 8'b1100_0000);
        tbl[23] = mk(1, 1, 0, 1,  8'b1111_0000);

        for (int i = 0; i < 24; i++) begin
            run(tbl[i].n, tbl[i].r, tbl[i].l, tbl[i].f);
            check($sformatf("table[%0d]", i), dut_vec, tbl[i].e);
        end

        // Glitchy lock: lock_s low seen at edge 25, ready 16 edges later.
        run(3, 0, 0, 0);
        run(13, 1, 0, 0);
        run(10, 1, 1, 0);
        step(1, 0, 0);
        hit = -1;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0);
            if (CLK_READY) begin
                hit = edge_no;
                break;
            end
        end
        check("glitch_ready_edge", hit, 41);

        // Lock never arrives: three attempts then FAULT at edge 230.
        run(2, 0, 0, 0);
        hit = -1;
        for (int i = 0; i < 400; i++) begin
            step(1, 0, (i % 7) == 3);
            if (edge_no == 80)  check("retry_after_first", RETRY_CNT, 1);
            if (edge_no == 160) check("retry_after_second", RETRY_CNT, 2);
            if (FAULT) begin
                hit = edge_no;
                break;
            end
        end
        check("fault_edge", hit, 230);
        check("fault_retry", RETRY_CNT, 3);
        for (int i = 0; i < 20; i++) step(1, i[0], i[1]);
        check("fault_sticky", dut_vec, 8'b0000_0111);
        step(0, 0, 0);
        check("fault_reset", dut_vec, 8'b0000_0000);

        // FF_REQ during WAIT_LOCK is deferred until RUN.
        run(2, 0, 1, 0);
        run(14, 1, 1, 0);
        run(14, 1, 1, 1);
        check("ff_in_wait_ignored", dut_vec, 8'b1100_0000);
        step(1, 1, 1);
        check("ff_deferred_run", dut_vec, 8'b1111_0000);
        step(1, 1, 1);
        check("ff_deferred_drain", dut_vec, 8'b1100_0000);

        // Reset during DRAIN, then during WAIT_LOCK.
        step(0, 1, 1);
        check("reset_in_drain", dut_vec, 8'b0000_0000);
        run(4, 1, 1, 0);
        check("restart_pd_edge3", dut_vec, 8'b0000_0000);
        step(1, 1, 0);
        check("restart_pd_edge4", dut_vec, 8'b1000_0000);
        run(8, 1, 1, 0);
        check("restart_arst_edge12", dut_vec, 8'b1100_0000);
        run(8, 1, 1, 0);
        step(0, 1, 0);
        check("reset_in_wait", dut_vec, 8'b0000_0000);
        run(28, 1, 1, 0);
        check("restart_edge27", dut_vec, 8'b1100_0000);
        step(1, 1, 0);
        check("restart_edge28", dut_vec, 8'b1111_0000);

        // Random stimulus against the model.
        lmode = 1;
        rf    = 1'b0;
        step(0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) lmode = $urandom_range(0, 3);
            rl = (lmode == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 79) == 0) rf = ~rf;
            step($urandom_range(0, 699) != 0, rl, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
